if_fetch_stage: RTL and testbench

Instruction-fetch stage sitting directly downstream of the PC register. It takes the current PC, runs a variable-latency req/ack read on instruction memory, and holds the PC until the fetch completes or ID is ready. It delivers the fetched word into the IF/ID pipeline register, with stall, flush and bubble insertion.

---
 rtl/if_fetch_stage.sv | 140 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: runs one req/ack read on instruction memory per PC,
// holds the PC until the word is accepted, and feeds the IF/ID pipeline register.
module if_fetch_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    output logic        pc_hold_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_plus4_o,
    output logic        valid_o,
    output logic [15:0] fetch_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        BUF,
        ADV,
        DRAIN
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [31:0] buf_q;
    logic [31:0] inst_q;
    logic [31:0] pc_plus4_q;
    logic        valid_q;
    logic [15:0] fetch_cnt_q;

    logic        load_en;
    logic [31:0] load_word;

    assign imem_req_o  = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr_o = addr_q;
    assign pc_hold_o   = !((state_q == ADV) || flush_i);

    assign inst_o      = inst_q;
    assign pc_plus4_o  = pc_plus4_q;
    assign valid_o     = valid_q;
    assign fetch_cnt_o = fetch_cnt_q;

    // A word enters IF/ID either straight from memory or from the stall buffer.
    always_comb begin
        load_en   = 1'b0;
        load_word = imem_data_i;
        if (!flush_i && !stall_i) begin
            if (state_q == FETCH && imem_ack_i) begin
                load_en = 1'b1;
            end else if (state_q == BUF) begin
                load_en   = 1'b1;
                load_word = buf_q;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            buf_q       <= 32'h0;
            inst_q      <= NOP_INST;
            pc_plus4_q  <= 32'h0;
            valid_q     <= 1'b0;
            fetch_cnt_q <= 16'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    addr_q  <= pc_i;
                end
                FETCH: begin
                    if (flush_i) begin
                        if (imem_ack_i) begin
                            addr_q <= pc_i;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end else if (imem_ack_i) begin
                        if (stall_i) begin
                            state_q <= BUF;
                            buf_q   <= imem_data_i;
                        end else begin
                            state_q <= ADV;
                        end
                    end
                end
                BUF: begin
                    if (flush_i) begin
                        state_q <= FETCH;
                        addr_q  <= pc_i;
                    end else if (!stall_i) begin
                        state_q <= ADV;
                    end
                end
                ADV: begin
                    state_q <= FETCH;
                    addr_q  <= pc_i;
                end
                DRAIN: begin
                    // The PC already holds the redirect target, so skip ADV.
                    if (imem_ack_i) begin
                        state_q <= FETCH;
                        addr_q  <= pc_i;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (flush_i) begin
                inst_q  <= NOP_INST;
                valid_q <= 1'b0;
            end else if (stall_i) begin
                inst_q  <= inst_q;
                valid_q <= valid_q;
            end else if (load_en) begin
                inst_q     <= load_word;
                pc_plus4_q <= addr_q + PC_INC;
                valid_q    <= 1'b1;
                if (fetch_cnt_q != 16'hFFFF) begin
                    fetch_cnt_q <= fetch_cnt_q + 16'd1;
                end
            end else begin
                inst_q  <= NOP_INST;
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then
// randomized memory/hazard traffic compared every cycle against a transaction model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] pc_i = 32'h0;
    logic        pc_hold_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = 32'h0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic [15:0] fetch_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    if_fetch_stage dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .pc_i        (pc_i),
        .pc_hold_o   (pc_hold_o),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .inst_o      (inst_o),
        .pc_plus4_o  (pc_plus4_o),
        .valid_o     (valid_o),
        .fetch_cnt_o (fetch_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Transaction view: has the stage started, is a read outstanding (and is it
    // already doomed by a flush), is a word parked, is the PC being released.
    logic        m_started, m_req, m_doomed, m_buffered, m_adv;
    logic [31:0] m_addr, m_buf;
    logic [31:0] e_inst, e_pc4;
    logic        e_valid;
    logic [15:0] e_cnt;

    task automatic modelReset();
        m_started  = 1'b0;
        m_req      = 1'b0;
        m_doomed   = 1'b0;
        m_buffered = 1'b0;
        m_adv      = 1'b0;
        m_addr     = 32'h0;
        m_buf      = 32'h0;
        e_inst     = NOP;
        e_pc4      = 32'h0;
        e_valid    = 1'b0;
        e_cnt      = 16'h0;
    endtask

    task automatic startRequest();
        m_req    = 1'b1;
        m_doomed = 1'b0;
        m_addr   = pc_i;
    endtask

    task automatic modelStep();
        logic        take;
        logic [31:0] word;
        take = !flush_i && !stall_i &&
               ((m_req && !m_doomed && imem_ack_i) || m_buffered);
        word = m_buffered ? m_buf : imem_data_i;

        if (flush_i) begin
            e_inst  = NOP;
            e_valid = 1'b0;
        end else if (!stall_i) begin
            if (take) begin
                e_inst  = word;
                e_pc4   = m_addr + 32'd4;
                e_valid = 1'b1;
                if (e_cnt < 16'hFFFF) e_cnt = e_cnt + 16'd1;
            end else begin
                e_inst  = NOP;
                e_valid = 1'b0;
            end
        end

        if (!m_started) begin
            m_started = 1'b1;
            startRequest();
        end else if (m_adv) begin
            m_adv = 1'b0;
            startRequest();
        end else if (m_buffered) begin
            if (flush_i) begin
                m_buffered = 1'b0;
                startRequest();
            end else if (!stall_i) begin
                m_buffered = 1'b0;
                m_adv      = 1'b1;
            end
        end else if (m_req) begin
            if (imem_ack_i) begin
                if (m_doomed || flush_i) begin
                    startRequest();
                end else if (stall_i) begin
                    m_req      = 1'b0;
                    m_buffered = 1'b1;
                    m_buf      = imem_data_i;
                end else begin
                    m_req = 1'b0;
                    m_adv = 1'b1;
                end
            end else if (flush_i) begin
                m_doomed = 1'b1;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkModel();
        checkOutput("imem_req_o", {31'b0, imem_req_o}, {31'b0, m_req});
        checkOutput("imem_addr_o", imem_addr_o, m_addr);
        checkOutput("pc_hold_o", {31'b0, pc_hold_o}, {31'b0, !(m_adv || flush_i)});
        checkOutput("inst_o", inst_o, e_inst);
        checkOutput("pc_plus4_o", pc_plus4_o, e_pc4);
        checkOutput("valid_o", {31'b0, valid_o}, {31'b0, e_valid});
        checkOutput("fetch_cnt_o", {16'b0, fetch_cnt_o}, {16'b0, e_cnt});
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic ack,
                                 input logic [31:0] data, input logic stall,
                                 input logic flush);
        @(negedge clk_i);
        rst_i       = 1'b0;
        pc_i        = pc;
        imem_ack_i  = ack;
        imem_data_i = data;
        stall_i     = stall;
        flush_i     = flush;
        #1;
        checkModel();
    endtask

    task automatic tick();
        @(posedge clk_i);
        if (!rst_i) modelStep();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " inst_o"}, inst_o, NOP);
        checkOutput({tag, " valid_o"}, {31'b0, valid_o}, 32'h0);
        checkOutput({tag, " imem_req_o"}, {31'b0, imem_req_o}, 32'h0);
        checkOutput({tag, " pc_hold_o"}, {31'b0, pc_hold_o}, 32'h1);
        checkOutput({tag, " fetch_cnt_o"}, {16'b0, fetch_cnt_o}, 32'h0);
        checkOutput({tag, " pc_plus4_o"}, pc_plus4_o, 32'h0);
    endtask

    task automatic doReset();
        #2;
        rst_i      = 1'b1;
        imem_ack_i = 1'b0;
        stall_i    = 1'b0;
        flush_i    = 1'b0;
        #1;
        checkResetOutputs("reset_mid");
        modelReset();
        @(posedge clk_i);
    endtask

    initial begin
        logic [15:0] sat_exp [3];
        sat_exp[0] = 16'hFFFE;
        sat_exp[1] = 16'hFFFF;
        sat_exp[2] = 16'hFFFF;

        modelReset();
        #1;
        checkResetOutputs("reset_init");
        @(posedge clk_i);

        // Reset while a request is outstanding
        applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 1'b0); tick();
        applyStimulus(32'h40, 1'b0, 32'h0, 1'b0, 1'b0); tick();
        applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("midfetch req", {31'b0, imem_req_o}, 32'h1);
        checkOutput("midfetch addr", imem_addr_o, 32'h40);
        doReset();
        applyStimulus(32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
        checkOutput("idle ignores ack", {31'b0, imem_req_o}, 32'h0);
        tick();
        applyStimulus(32'h0, 1'b1, 32'h13, 1'b0, 1'b0);
        checkOutput("first addr after reset", imem_addr_o, 32'h0);
        checkOutput("first req after reset", {31'b0, imem_req_o}, 32'h1);
        tick();
        applyStimulus(32'h100, 1'b0, 32'h0, 1'b0, 1'b0); tick();

        // Zero-wait fetch at 0x100
        applyStimulus(32'h100, 1'b1, 32'h8C22_0004, 1'b0, 1'b0);
        checkOutput("zw addr", imem_addr_o, 32'h100);
        tick();
        applyStimulus(32'h104, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("zw inst", inst_o, 32'h8C22_0004);
        checkOutput("zw pc_plus4", pc_plus4_o, 32'h104);
        checkOutput("zw valid", {31'b0, valid_o}, 32'h1);
        checkOutput("zw hold in ADV", {31'b0, pc_hold_o}, 32'h0);
        tick();

        // Three wait states
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h104, (i == 3), 32'hAAAA_0001, 1'b0, 1'b0);
            checkOutput("wait addr", imem_addr_o, 32'h104);
            checkOutput("wait hold", {31'b0, pc_hold_o}, 32'h1);
            checkOutput("wait valid", {31'b0, valid_o}, 32'h0);
            tick();
        end
        applyStimulus(32'h108, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("wait inst", inst_o, 32'hAAAA_0001);
        checkOutput("wait pc_plus4", pc_plus4_o, 32'h108);
        tick();

        // Stall when ack arrives
        applyStimulus(32'h108, 1'b1, 32'h5555_0002, 1'b1, 1'b0); tick();
        applyStimulus(32'h108, 1'b0, 32'h0, 1'b1, 1'b0);
        checkOutput("buf req", {31'b0, imem_req_o}, 32'h0);
        checkOutput("buf hold", {31'b0, pc_hold_o}, 32'h1);
        checkOutput("buf valid", {31'b0, valid_o}, 32'h0);
        tick();
        applyStimulus(32'h108, 1'b0, 32'h0, 1'b0, 1'b0); tick();
        applyStimulus(32'h10C, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("buf inst", inst_o, 32'h5555_0002);
        checkOutput("buf pc_plus4", pc_plus4_o, 32'h10C);
        checkOutput("buf hold release", {31'b0, pc_hold_o}, 32'h0);
        tick();

        // Flush with the ack arriving two cycles later
        applyStimulus(32'h10C, 1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("flush hold", {31'b0, pc_hold_o}, 32'h0);
        tick();
        applyStimulus(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("drain addr", imem_addr_o, 32'h10C);
        checkOutput("drain req", {31'b0, imem_req_o}, 32'h1);
        tick();
        applyStimulus(32'h200, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0); tick();
        applyStimulus(32'h200, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("post-flush addr", imem_addr_o, 32'h200);
        checkOutput("post-flush valid", {31'b0, valid_o}, 32'h0);
        checkOutput("post-flush cnt", {16'b0, fetch_cnt_o}, 32'd4);
        tick();

        // Flush and stall together clear IF/ID
        applyStimulus(32'h200, 1'b1, 32'h0BAD_0003, 1'b0, 1'b0); tick();
        applyStimulus(32'h204, 1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("pre-flush valid", {31'b0, valid_o}, 32'h1);
        tick();
        applyStimulus(32'hFFFF_FFFC, 1'b1, 32'h1, 1'b0, 1'b0);
        checkOutput("flush+stall valid", {31'b0, valid_o}, 32'h0);
        checkOutput("flush+stall inst", inst_o, NOP);
        tick();

        // Address wrap
        applyStimulus(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b0); tick();
        applyStimulus(32'h0, 1'b1, 32'h2, 1'b0, 1'b0);
        checkOutput("wrap addr", imem_addr_o, 32'hFFFF_FFFC);
        tick();
        applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("wrap pc_plus4", pc_plus4_o, 32'h0);
        checkOutput("wrap cnt", {16'b0, fetch_cnt_o}, 32'd7);
        tick();

        // Counter saturation from a preloaded value
        applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        force dut.fetch_cnt_q = 16'hFFFD;
        #1;
        release dut.fetch_cnt_q;
        e_cnt = 16'hFFFD;
        tick();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(32'h0, 1'b1, 32'h100 + k, 1'b0, 1'b0); tick();
            applyStimulus(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
            checkOutput("saturate cnt", {16'b0, fetch_cnt_o}, {16'b0, sat_exp[k]});
            tick();
        end

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus({$urandom()} & 32'hFFFF_FFFC,
                          ($urandom_range(0, 99) < 40),
                          $urandom(),
                          ($urandom_range(0, 99) < 25),
                          ($urandom_range(0, 99) < 8));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
